imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 207 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for a pipeline core. It accepts a stream of 32-bit
// instruction words over a valid/ready handshake and writes each one into the
// core's instruction memory at consecutive word addresses starting at
// BASE_ADDR. While the image is loading, and for HOLD_CYCLES cycles after
// the last write, the core is held in reset. After that the core runs until
// a reload request restarts the whole sequence.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   When defined, every accepted word is XOR-accumulated. On the final word
//   the accumulated value (including that word) is compared against ld_chk.
//   On a mismatch the loader parks in the FAIL state with load_err = 1 and
//   the core stays in reset until reload. When undefined, ld_chk is ignored,
//   load_err is tied low and FAIL can never be reached.
//
// Parameters:
//   DEPTH       - maximum number of words per load (power of two, 2..4096)
//   BASE_ADDR   - byte address of the first loaded word
//   HOLD_CYCLES - cycles the core reset stays low after the last write (>=1)
//
// Ports:
//   clk         in   1  rising-edge clock
//   reset_n     in   1  asynchronous active-low reset
//   ld_valid    in   1  ld_data holds a program word
//   ld_data     in  32  program word
//   ld_last     in   1  marks the final word of the image
//   ld_ready    out  1  loader accepts a word this cycle
//   reload      in   1  single-cycle request to restart loading
//   ld_chk      in  32  expected XOR checksum, sampled with the last word
//   tb_we       out  1  one-cycle instruction-memory write strobe
//   tb_addr     out 32  instruction-memory byte address
//   tb_inst     out 32  instruction-memory write data
//   cpu_reset_n out  1  active-low reset to the pipeline core
//   word_cnt    out 13  words accepted in the current load
//   load_err    out  1  checksum mismatch flag
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        reload,
  input  logic [31:0] ld_chk,
  output logic        tb_we,
  output logic [31:0] tb_addr,
  output logic [31:0] tb_inst,
  output logic        cpu_reset_n,
  output logic [12:0] word_cnt,
  output logic        load_err
);

  localparam int unsigned HW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [12:0] LAST_IDX = 13'(DEPTH - 1);
  localparam logic [12:0] MAX_CNT  = 13'(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          xfer;
  logic          final_xfer;
  logic          chk_bad;

  // A word moves only while ld_ready is high, which is only ever in LOAD.
  // The final word is either flagged by the source or forced when the
  // memory window is full, so the counter can never pass DEPTH.
  assign xfer       = ld_valid && ld_ready;
  assign final_xfer = ld_last || (word_cnt == LAST_IDX);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] acc;
  logic        err_q;

  // The comparison folds in the word on the bus so the last word counts
  // without waiting a cycle for the accumulator to catch up.
  assign chk_bad  = ((acc ^ ld_data) != ld_chk);
  assign load_err = err_q;

  // Checksum accumulator and error flag. Cleared whenever a reload starts a
  // fresh image; a LOAD-state reload is ignored just like in the main FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= 32'h0;
      err_q <= 1'b0;
    end else if (state == S_LOAD) begin
      if (xfer) begin
        acc <= acc ^ ld_data;
        if (final_xfer && chk_bad) begin
          err_q <= 1'b1;
        end
      end
    end else if (reload) begin
      acc   <= 32'h0;
      err_q <= 1'b0;
    end
  end
`else
  logic unused_chk;

  assign unused_chk = ^ld_chk;
  assign chk_bad    = 1'b0;
  assign load_err   = 1'b0;
`endif

  // Main loader FSM. All outputs are registered here so cpu_reset_n cannot
  // glitch. ld_ready comes out of reset low and rises on the first edge
  // after release. A reload in HOLD/RUN/FAIL reopens the window at once;
  // tb_addr/tb_inst are only touched on a write so they hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_LOAD;
      ld_ready    <= 1'b0;
      tb_we       <= 1'b0;
      tb_addr     <= BASE_ADDR;
      tb_inst     <= 32'h0;
      cpu_reset_n <= 1'b0;
      word_cnt    <= 13'd0;
      hold_cnt    <= '0;
    end else begin
      tb_we <= 1'b0;
      case (state)
        S_LOAD: begin
          ld_ready    <= 1'b1;
          cpu_reset_n <= 1'b0;
          if (xfer) begin
            tb_we   <= 1'b1;
            tb_addr <= BASE_ADDR + {17'd0, word_cnt, 2'b00};
            tb_inst <= ld_data;
            if (word_cnt != MAX_CNT) begin
              word_cnt <= word_cnt + 13'd1;
            end
            if (final_xfer) begin
              ld_ready <= 1'b0;
              if (chk_bad) begin
                state <= S_FAIL;
              end else begin
                state    <= S_HOLD;
                hold_cnt <= HW'(HOLD_CYCLES);
              end
            end
          end
        end

        // The core is released on the edge where the counter hits zero,
        // i.e. HOLD_CYCLES edges after the final write was accepted.
        S_HOLD: begin
          ld_ready    <= 1'b0;
          cpu_reset_n <= 1'b0;
          if (reload) begin
            state    <= S_LOAD;
            ld_ready <= 1'b1;
            word_cnt <= 13'd0;
            hold_cnt <= '0;
          end else if (hold_cnt <= HW'(1)) begin
            state       <= S_RUN;
            cpu_reset_n <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end

        S_RUN: begin
          if (reload) begin
            state       <= S_LOAD;
            ld_ready    <= 1'b1;
            cpu_reset_n <= 1'b0;
            word_cnt    <= 13'd0;
          end else begin
            ld_ready    <= 1'b0;
            cpu_reset_n <= 1'b1;
          end
        end

        S_FAIL: begin
          ld_ready    <= 1'b0;
          cpu_reset_n <= 1'b0;
          if (reload) begin
            state    <= S_LOAD;
            ld_ready <= 1'b1;
            word_cnt <= 13'd0;
          end
        end

        default: begin
          state       <= S_LOAD;
          ld_ready    <= 1'b0;
          cpu_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed self-checking bench for imem_loader. Two instances share the same
// input stimulus: "dut" uses default parameters, "dut4" uses DEPTH = 4 to
// exercise the forced end of a load. Memory writes of each instance are
// captured on the falling clock edge into queues and compared against
// hand-computed address/data pairs.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int HOLD = 4;

  logic        clk;
  logic        reset_n;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        reload;
  logic [31:0] ld_chk;

  logic        ld_ready,    ld_ready4;
  logic        tb_we,       tb_we4;
  logic [31:0] tb_addr,     tb_addr4;
  logic [31:0] tb_inst,     tb_inst4;
  logic        cpu_reset_n, cpu_reset_n4;
  logic [12:0] word_cnt,    word_cnt4;
  logic        load_err,    load_err4;

  logic [63:0] wq[$];
  logic [63:0] wq4[$];

  int checks = 0;
  int errors = 0;

  imem_loader #(
    .DEPTH(256), .BASE_ADDR(32'h0000_0000), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .reload(reload), .ld_chk(ld_chk),
    .tb_we(tb_we), .tb_addr(tb_addr), .tb_inst(tb_inst),
    .cpu_reset_n(cpu_reset_n), .word_cnt(word_cnt), .load_err(load_err)
  );

  imem_loader #(
    .DEPTH(4), .BASE_ADDR(32'h0000_0000), .HOLD_CYCLES(HOLD)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready4), .reload(reload), .ld_chk(ld_chk),
    .tb_we(tb_we4), .tb_addr(tb_addr4), .tb_inst(tb_inst4),
    .cpu_reset_n(cpu_reset_n4), .word_cnt(word_cnt4), .load_err(load_err4)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every memory write mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (tb_we)  wq.push_back({tb_addr, tb_inst});
    if (tb_we4) wq4.push_back({tb_addr4, tb_inst4});
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkWrite(input string tag, input bit sel4, input int idx,
                            input logic [31:0] ea, input logic [31:0] ed);
    logic [63:0] ent;
    int n;
    n   = sel4 ? wq4.size() : wq.size();
    ent = '1;
    if (idx < n) ent = sel4 ? wq4[idx] : wq[idx];
    checkOutput({tag, "_addr"}, ent[63:32], ea);
    checkOutput({tag, "_inst"}, ent[31:0], ed);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, let the edge happen, then drop the strobes.
  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic last, input logic [31:0] chk,
                               input logic rl);
    ld_valid = v;
    ld_data  = d;
    ld_last  = last;
    ld_chk   = chk;
    reload   = rl;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    reload   = 1'b0;
  endtask

  task automatic applyReset();
    ld_valid = 1'b0;
    ld_data  = 32'h0;
    ld_last  = 1'b0;
    reload   = 1'b0;
    ld_chk   = 32'h0;
    reset_n  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    wq.delete();
    wq4.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    applyReset();

    // Ready rises on the first edge after release.
    checkOutput("rst_ready", ld_ready, 1'b1);
    checkOutput("rst_cpu", cpu_reset_n, 1'b0);
    checkOutput("rst_cnt", word_cnt, 13'd0);
    checkOutput("rst_err", load_err, 1'b0);

    // Three-word program, last flagged on the third word.
    $display("[TB] basic three-word load");
    applyStimulus(1, 32'h0050_0093, 0, 32'h0, 0);
    applyStimulus(1, 32'h00A0_0113, 0, 32'h0, 0);
    applyStimulus(1, 32'h0020_81B3, 1, 32'h0, 0);
    checkOutput("t1_we", tb_we, 1'b1);
    checkOutput("t1_ready_hold", ld_ready, 1'b0);
    for (int i = 0; i < HOLD - 1; i++) begin
      tick();
      checkOutput("t1_cpu_held", cpu_reset_n, 1'b0);
    end
    tick();
    checkOutput("t1_cpu_run", cpu_reset_n, 1'b1);
    checkOutput("t1_cnt", word_cnt, 13'd3);
    checkOutput("t1_nwrites", wq.size(), 32'd3);
    checkWrite("t1_w0", 0, 0, 32'h0, 32'h0050_0093);
    checkWrite("t1_w1", 0, 1, 32'h4, 32'h00A0_0113);
    checkWrite("t1_w2", 0, 2, 32'h8, 32'h0020_81B3);
    checkOutput("t1_addr_hold", tb_addr, 32'h8);
    checkOutput("t1_inst_hold", tb_inst, 32'h0020_81B3);

    // Reload from RUN and load a single NOP.
    $display("[TB] reload from run");
    wq.delete();
    applyStimulus(0, 32'h0, 0, 32'h0, 1);
    checkOutput("t2_cpu_low", cpu_reset_n, 1'b0);
    checkOutput("t2_cnt_clr", word_cnt, 13'd0);
    checkOutput("t2_ready", ld_ready, 1'b1);
    applyStimulus(1, 32'h0000_0013, 1, 32'h0, 0);
    for (int i = 0; i < HOLD - 1; i++) begin
      tick();
      checkOutput("t2_cpu_held", cpu_reset_n, 1'b0);
    end
    tick();
    checkOutput("t2_cpu_run", cpu_reset_n, 1'b1);
    checkOutput("t2_nwrites", wq.size(), 32'd1);
    checkWrite("t2_w0", 0, 0, 32'h0, 32'h0000_0013);

    // Reset in the middle of a five-word load.
    $display("[TB] reset mid-load");
    applyReset();
    applyStimulus(1, 32'h1111_1111, 0, 32'h0, 0);
    applyStimulus(1, 32'h2222_2222, 0, 32'h0, 0);
    checkOutput("t3_cnt_pre", word_cnt, 13'd2);
    reset_n = 1'b0;
    #1;
    checkOutput("t3_we", tb_we, 1'b0);
    checkOutput("t3_addr", tb_addr, 32'h0);
    checkOutput("t3_inst", tb_inst, 32'h0);
    checkOutput("t3_cnt", word_cnt, 13'd0);
    checkOutput("t3_ready", ld_ready, 1'b0);
    checkOutput("t3_cpu", cpu_reset_n, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    wq.delete();
    applyStimulus(1, 32'h3333_3333, 0, 32'h0, 0);
    tick();
    checkOutput("t3_nwrites", wq.size(), 32'd1);
    checkWrite("t3_w0", 0, 0, 32'h0, 32'h3333_3333);

    // Valid toggling every other cycle, last on the second word.
    $display("[TB] gapped valid");
    applyReset();
    applyStimulus(1, 32'hAAAA_0001, 0, 32'h0, 0);
    applyStimulus(0, 32'hDEAD_0000, 0, 32'h0, 0);
    applyStimulus(1, 32'hAAAA_0002, 1, 32'h0, 0);
    applyStimulus(0, 32'hDEAD_0001, 0, 32'h0, 0);
    tick();
    checkOutput("t4_nwrites", wq.size(), 32'd2);
    checkWrite("t4_w0", 0, 0, 32'h0, 32'hAAAA_0001);
    checkWrite("t4_w1", 0, 1, 32'h4, 32'hAAAA_0002);
    checkOutput("t4_cnt", word_cnt, 13'd2);

    // Six words with no last: DEPTH=4 instance stops after four.
    $display("[TB] forced end at depth");
    applyReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'h10 + 32'(i), 0, 32'h0, 0);
    end
    tick();
    checkOutput("t5_nwrites", wq4.size(), 32'd4);
    checkWrite("t5_w0", 1, 0, 32'h0, 32'h10);
    checkWrite("t5_w1", 1, 1, 32'h4, 32'h11);
    checkWrite("t5_w2", 1, 2, 32'h8, 32'h12);
    checkWrite("t5_w3", 1, 3, 32'hC, 32'h13);
    checkOutput("t5_cnt4", word_cnt4, 13'd4);
    checkOutput("t5_ready4", ld_ready4, 1'b0);
    checkOutput("t5_cnt_big", word_cnt, 13'd6);

    // Reload is ignored in LOAD; a transfer with reload still goes through.
    applyStimulus(0, 32'h0, 0, 32'h0, 1);
    checkOutput("t5_reload_ign", word_cnt, 13'd6);
    applyStimulus(1, 32'h55, 0, 32'h0, 1);
    checkOutput("t5_xfer_wins", word_cnt, 13'd7);
    checkOutput("t5_xfer_addr", tb_addr, 32'h18);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum good");
    applyReset();
    applyStimulus(1, 32'h1, 0, 32'h0, 0);
    applyStimulus(1, 32'h2, 1, 32'h3, 0);
    for (int i = 0; i < HOLD; i++) tick();
    checkOutput("t6_cpu_run", cpu_reset_n, 1'b1);
    checkOutput("t6_err_ok", load_err, 1'b0);

    $display("[TB] checksum bad");
    applyReset();
    applyStimulus(1, 32'h1, 0, 32'h0, 0);
    applyStimulus(1, 32'h2, 1, 32'h4, 0);
    checkOutput("t6_err_set", load_err, 1'b1);
    for (int i = 0; i < HOLD + 1; i++) tick();
    checkOutput("t6_cpu_stuck", cpu_reset_n, 1'b0);
    checkOutput("t6_err_stuck", load_err, 1'b1);
    applyStimulus(0, 32'h0, 0, 32'h0, 1);
    checkOutput("t6_err_clr", load_err, 1'b0);
    checkOutput("t6_ready", ld_ready, 1'b1);
    checkOutput("t6_cnt_clr", word_cnt, 13'd0);
`else
    // Without the feature the flag is tied low even with a wrong checksum.
    applyReset();
    applyStimulus(1, 32'h1, 0, 32'h0, 0);
    applyStimulus(1, 32'h2, 1, 32'h4, 0);
    for (int i = 0; i < HOLD; i++) tick();
    checkOutput("t6_noerr", load_err, 1'b0);
    checkOutput("t6_cpu_run", cpu_reset_n, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
